// File: rtl/mac_pkg.sv
// Shared constants and activation encoding for the mac datapath and its
// output post-processing stage.
package mac_pkg;

  localparam int MAC_DW = 32;
  localparam int MAC_OW = 8;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_RELU6 = 2'b10
  } act_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Output is zero when empty and a
// write into a full FIFO is accepted only when a read happens in the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_ok;

  assign full     = (count == LW'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign wr_ok    = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;
  assign rd_data  = rd_valid ? mem[rptr] : '0;
  assign level    = count;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_postproc.sv
// Post-processing of mac results: bias add, rounded arithmetic shift,
// activation, saturation to OW bits, then buffering in an output FIFO.
module mac_postproc
  import mac_pkg::*;
#(
  parameter int DW        = MAC_DW,
  parameter int OW        = MAC_OW,
  parameter int DEPTH     = 4,
  parameter int RELU6_MAX = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              in_result,
  input  logic                       in_valid,
  input  logic [DW-1:0]              bias,
  input  logic [4:0]                 cfg_shift,
  input  logic [1:0]                 cfg_act,
  output logic [OW-1:0]              out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int XW = DW + 2;
  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] R6   = XW'(RELU6_MAX);
  localparam logic signed [XW-1:0] OMAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [DW:0]   s1_sum;
  logic [4:0]           s1_shift;
  logic [1:0]           s1_act;
  logic                 s1_valid;

  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] wide;
  logic signed [XW-1:0] rounded;
  logic signed [XW-1:0] acted;
  logic [OW-1:0]        res;

  logic [OW-1:0]        s2_data;
  logic                 s2_valid;
  logic                 drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_act   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum   <= $signed({in_result[DW-1], in_result}) + $signed({bias[DW-1], bias});
        s1_shift <= cfg_shift;
        s1_act   <= cfg_act;
      end
    end
  end

  // One extra bit of headroom keeps the rounding addend from wrapping the sum.
  always_comb begin
    rnd = '0;
    if (s1_shift != 5'd0) rnd = ONE << (s1_shift - 5'd1);
    wide    = $signed({s1_sum[DW], s1_sum}) + rnd;
    rounded = wide >>> s1_shift;

    acted = rounded;
    if ((s1_act == ACT_RELU || s1_act == ACT_RELU6) && rounded[XW-1]) acted = '0;
    if (s1_act == ACT_RELU6 && rounded > R6) acted = R6;

    if (acted > OMAX)      res = OMAX[OW-1:0];
    else if (acted < OMIN) res = OMIN[OW-1:0];
    else                   res = acted[OW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= res;
    end
  end

  sync_fifo #(
    .W     (OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (s2_valid),
    .wr_data  (s2_data),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .level    (fifo_level),
    .drop     (drop)
  );

  // A drop in the same cycle as a clear wins, so no lost result goes unflagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_mac_postproc.sv
// Directed self-checking bench for mac_postproc with hand-computed results.
module tb_mac_postproc;
  import mac_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] in_result;
  logic        in_valid;
  logic [31:0] bias;
  logic [4:0]  cfg_shift;
  logic [1:0]  cfg_act;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mac_postproc #(.DW(32), .OW(8), .DEPTH(4), .RELU6_MAX(96)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_result  (in_result),
    .in_valid   (in_valid),
    .bias       (bias),
    .cfg_shift  (cfg_shift),
    .cfg_act    (cfg_act),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0]       r;
    logic [31:0]       b;
    logic [4:0]        s;
    logic [1:0]        a;
    logic signed [7:0] e;
  } vec_t;

  task automatic strobe(input logic [31:0] r, input logic [31:0] b,
                        input logic [4:0] s, input logic [1:0] a);
    in_result = r;
    bias      = b;
    cfg_shift = s;
    cfg_act   = a;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic get_result(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin
      d = out_data;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_result = 0; bias = 0; cfg_shift = 0;
    cfg_act = 0; out_ready = 0; clr_ovf = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_latency();
    strobe(32'd1000, 32'd24, 5'd4, ACT_NONE);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n1 got=%b want=0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n2 got=%b want=0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_n3_valid got=%b want=1", out_valid); end
    n_checks++; if (out_data !== 8'd64) begin n_fail++; $display("FAIL latency_n3_data got=%0d want=64", $signed(out_data)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_pop got=%b want=0", out_valid); end
  endtask

  task automatic test_vectors();
    vec_t v[14] = '{
      '{32'd1000,       32'd24,         5'd4,  ACT_NONE,  8'sd64},
      '{-32'sd5000,     32'd0,          5'd2,  ACT_RELU,  8'sd0},
      '{-32'sd5000,     32'd0,          5'd2,  ACT_NONE,  -8'sd128},
      '{32'd4000,       32'd0,          5'd3,  ACT_RELU6, 8'sd96},
      '{32'd23,         32'd0,          5'd1,  ACT_NONE,  8'sd12},
      '{-32'sd7,        32'd2,          5'd0,  ACT_NONE,  -8'sd5},
      '{32'd200,        -32'sd100,      5'd0,  ACT_RELU,  8'sd100},
      '{-32'sd50,       32'd0,          5'd0,  ACT_RELU6, 8'sd0},
      '{-32'sd3,        32'd0,          5'd1,  ACT_NONE,  -8'sd1},
      '{32'h7fffffff,   32'h7fffffff,   5'd31, ACT_NONE,  8'sd2},
      '{32'd500,        32'd0,          5'd0,  ACT_NONE,  8'sd127},
      '{-32'sd23,       32'd0,          5'd1,  2'b11,     -8'sd11},
      '{32'd90,         32'd0,          5'd0,  ACT_RELU6, 8'sd90},
      '{32'd97,         32'd0,          5'd0,  ACT_RELU6, 8'sd96}
    };
    logic [7:0] d;
    bit ok;
    for (int i = 0; i < 14; i++) begin
      strobe(v[i].r, v[i].b, v[i].s, v[i].a);
      get_result(d, ok);
      n_checks++;
      if (!ok || d !== v[i].e) begin
        n_fail++;
        $display("FAIL vec%0d got=%0d (valid_seen=%0b) want=%0d", i, $signed(d), ok, v[i].e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    bit ok;
    for (int c = 0; c < 6; c++) strobe(32'(c + 1), 32'd0, 5'd0, ACT_NONE);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got=%0d want=4", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    n_checks++; if (out_data !== 8'd1) begin n_fail++; $display("FAIL ovf_head_stable got=%0d want=1", out_data); end
    for (int i = 0; i < 4; i++) begin
      get_result(d, ok);
      n_checks++;
      if (!ok || d !== 8'(i + 1)) begin n_fail++; $display("FAIL ovf_order%0d got=%0d want=%0d", i, d, i + 1); end
    end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_drained got=%0d want=0", fifo_level); end
    clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want=0", overflow); end

    // fifth result is dropped on the edge that closes cycle 6, same as the clear
    for (int c = 0; c < 8; c++) begin
      in_valid  = (c < 5);
      in_result = 32'(c + 10);
      clr_ovf   = (c == 6);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop got=%b want=1", overflow); end
    clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
    out_ready = 1'b1; repeat (5) begin @(posedge clk); #1; end out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_cleanup level=%0d ovf=%b want=0/0", fifo_level, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int exp = 1;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (c < 12);
      in_result = 32'(c + 1);
      cfg_shift = 5'd0;
      cfg_act   = ACT_NONE;
      bias      = 32'd0;
      out_ready = (c >= 6);
      #1;
      if (c >= 6 && c <= 14) begin
        n_checks++;
        if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL stream_level c=%0d got=%0d want=4", c, fifo_level); end
      end
      if (out_ready && out_valid) begin
        n_checks++;
        if (out_data !== 8'(exp)) begin n_fail++; $display("FAIL stream_data got=%0d want=%0d", out_data, exp); end
        exp++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (exp !== 13) begin n_fail++; $display("FAIL stream_count got=%0d want=12", exp - 1); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stream_no_drop got=%b want=0", overflow); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    bit ok;
    for (int c = 0; c < 5; c++) strobe(32'(c + 50), 32'd0, 5'd0, ACT_NONE);
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_setup_level got=%0d want=3", fifo_level); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL mid_reset valid=%b level=%0d want=0/0", out_valid, fifo_level);
    end
    n_checks++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL mid_reset_data got=%0d want=0", out_data); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    n_checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL mid_no_stale valid=%b level=%0d want=0/0", out_valid, fifo_level);
    end
    strobe(32'd7, 32'd0, 5'd0, ACT_NONE);
    get_result(d, ok);
    n_checks++; if (!ok || d !== 8'd7) begin n_fail++; $display("FAIL mid_first_new got=%0d want=7", d); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
